// File: rtl/uart_pkg.sv
// Shared UART types: parity mode and receiver state encodings, plus a
// 2-of-3 vote helper used by the majority-sampling build of the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running counter 0..baud_div-1, one-cycle
// tick on the wrap cycle. A divisor of 0 behaves as 1 (tick every cycle).
// The >= compare lets a shrinking divisor wrap at once instead of running
// the counter all the way round.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_last;

    assign cnt_last = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    assign tick     = (cnt >= cnt_last);

    // divisor counter, reloads to 0 on the tick cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with ready/valid output and per-frame error flags.
// Optional build macro UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote of the
// ticks at mid-1, mid and mid+1; otherwise the mid tick alone is used.
// The bit decision is always taken on the mid+1 tick (the mid sample is held
// one tick), so frame timing is identical in both builds.
module uart_rx_param import uart_pkg::*; #(
    parameter int DATA_W      = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int HALF = OVERSAMPLE / 2;
    localparam int TW   = $clog2(OVERSAMPLE);
    localparam int BW   = $clog2(DATA_W);

    rx_state_t         state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              rx_s;
    logic              tick;
    logic              bit_s;
    logic              samp;
    logic              par_en;
    logic              last_data;
    logic              last_stop;
    logic              frame_done;
    logic [TW-1:0]     tcnt;
    logic [BW-1:0]     bitcnt;
    logic [DATA_W-1:0] shreg;
    logic              par_err_q;
    logic              ferr_q;

    // input synchroniser, idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
    assign rx_s = sync_q[SYNC_STAGES-1];

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .baud_div (baud_div),
        .tick     (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    // last two tick samples; with the live line they form the 3-tick window
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hist <= '1;
        else if (tick)
            hist <= {hist[0], rx_s};
    end
    assign bit_s = maj3(hist[1], hist[0], rx_s);
`else
    logic hist;
    // previous tick sample, i.e. the mid tick when the decision is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hist <= 1'b1;
        else if (tick)
            hist <= rx_s;
    end
    assign bit_s = hist;
`endif

    assign par_en    = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
    assign last_data = (bitcnt == BW'(DATA_W - 1));
    assign last_stop = (bitcnt == BW'(STOP_BITS - 1));
    assign samp      = tick && (((state == START) && (tcnt == TW'(HALF))) ||
                       (((state == DATA) || (state == PARITY) || (state == STOP)) &&
                        (tcnt == TW'(OVERSAMPLE - 1))));

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic, advanced on bit decisions
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick && !rx_s) state_nxt = START;
            START:   if (samp) state_nxt = bit_s ? IDLE : DATA;
            DATA:    if (samp && last_data) state_nxt = par_en ? PARITY : STOP;
            PARITY:  if (samp) state_nxt = STOP;
            STOP:    if (samp && last_stop) state_nxt = bit_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state-derived outputs
    always_comb begin
        busy       = (state != IDLE);
        frame_done = samp && (state == STOP) && last_stop;
    end

    // tick/bit counters, shift register and per-frame error accumulators
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt      <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            par_err_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else if ((state == IDLE) || (state == BREAK)) begin
            tcnt      <= '0;
            bitcnt    <= '0;
            par_err_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else if (tick) begin
            tcnt <= samp ? '0 : tcnt + TW'(1);
            if (samp) begin
                case (state)
                    DATA: begin
                        shreg  <= {bit_s, shreg[DATA_W-1:1]};
                        bitcnt <= last_data ? '0 : bitcnt + BW'(1);
                    end
                    PARITY: begin
                        if (parity_mode == PAR_EVEN)
                            par_err_q <= ((^shreg) != bit_s);
                        else
                            par_err_q <= ((^shreg) == bit_s);
                    end
                    STOP: begin
                        bitcnt <= last_stop ? '0 : bitcnt + BW'(1);
                        if (!bit_s) ferr_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // output holding register: load on completion unless an undelivered word is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data       <= shreg;
                    rx_parity_err <= par_err_q;
                    rx_frame_err  <= ferr_q | ~bit_s;
                    rx_valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
